// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller: FSM encoding, source indices, default widths.
package mm_trap_pkg;

    localparam int unsigned DEF_NUM_SRC     = 4;
    localparam int unsigned DEF_CAUSE_W     = 2;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMESLICE_W = 16;

    localparam int unsigned SRC_IRQ = 0;
    localparam int unsigned SRC_IO  = 1;

    // Encoding equals the trap_state output bit.
    typedef enum logic {
        ST_GUEST = 1'b0,
        ST_HOST  = 1'b1
    } state_e;

    // The timeslice preemption source always occupies the top index.
    function automatic int unsigned src_timeslice(input int unsigned num_src);
        return num_src - 1;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Bus bundle between the Nabu glue / Z80 pins and the trap controller.
interface trap_controller_if #(
    parameter int unsigned NUM_SRC     = mm_trap_pkg::DEF_NUM_SRC,
    parameter int unsigned CAUSE_W     = mm_trap_pkg::DEF_CAUSE_W,
    parameter int unsigned TIMESLICE_W = mm_trap_pkg::DEF_TIMESLICE_W
);
    logic                   m1_n;
    logic                   irq_sys_n;
    logic [NUM_SRC-1:0]     trap_req;
    logic [NUM_SRC-1:0]     trap_mask;
    logic                   new_isr;
    logic                   last_isr_jmp;
    logic                   virtual_enabled;
    logic [TIMESLICE_W-1:0] timeslice_limit;

    logic                   trap_state;
    logic                   nmi_n;
    logic                   irq_n;
    logic                   capture_address;
    logic [CAUSE_W-1:0]     trap_cause;
    logic                   cause_valid;
    logic [NUM_SRC-1:0]     pending;

    modport slave (
        input  m1_n, irq_sys_n, trap_req, trap_mask, new_isr, last_isr_jmp,
               virtual_enabled, timeslice_limit,
        output trap_state, nmi_n, irq_n, capture_address, trap_cause,
               cause_valid, pending
    );

    modport master (
        output m1_n, irq_sys_n, trap_req, trap_mask, new_isr, last_isr_jmp,
               virtual_enabled, timeslice_limit,
        input  trap_state, nmi_n, irq_n, capture_address, trap_cause,
               cause_valid, pending
    );
endinterface

// File: rtl/trap_controller_m1_edge_sync.sv
// Multi-flop synchroniser for an async active-low Z80 signal plus registered rise/fall pulses.
module m1_edge_sync #(
    parameter int unsigned STAGES = mm_trap_pkg::DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_fall;
    logic              r_rise;
    logic              w_sync;

    assign w_sync = r_sync[STAGES-1];

    // Idle level of both Z80 lines is high, so the chain resets to 1 to avoid a spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= w_sync;
            r_fall <= r_prev & ~w_sync;
            r_rise <= ~r_prev & w_sync;
        end
    end

    assign o_sync = w_sync;
    assign o_fall = r_fall;
    assign o_rise = r_rise;
endmodule

// File: rtl/trap_controller.sv
// Host/guest trap FSM and NMI arbiter for the Nabu MegaMapper.
// Optional timeslice preemption is built when TRAP_TIMESLICE_EN is defined.
module trap_controller
    import mm_trap_pkg::*;
#(
    parameter int unsigned NUM_SRC     = DEF_NUM_SRC,
    parameter int unsigned CAUSE_W     = DEF_CAUSE_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMESLICE_W = DEF_TIMESLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    trap_controller_if.slave bus
);
    localparam int unsigned SRC_TS = src_timeslice(NUM_SRC);

    state_e               r_state;
    state_e               w_state_next;
    logic [NUM_SRC-1:0]   r_pending;
    logic                 r_suppress;
    logic                 r_nmi_n;
    logic                 r_irq_n;
    logic                 r_capture;
    logic [CAUSE_W-1:0]   r_cause;
    logic                 r_cause_valid;

    logic                 w_m1_fall;
    logic                 w_m1_rise;
    logic                 w_irq_sync;
    logic                 w_unused_m1_sync;
    logic                 w_unused_irq_fall;
    logic                 w_unused_irq_rise;

    logic                 w_trap_entry;
    logic                 w_forced_entry;
    logic                 w_resume;
    logic [NUM_SRC-1:0]   w_set;
    logic [NUM_SRC-1:0]   w_clr;
    logic [CAUSE_W-1:0]   w_cause_idx;
    logic                 w_ts_hit;

    m1_edge_sync #(.STAGES(SYNC_STAGES)) u_m1_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.m1_n),
        .o_sync  (w_unused_m1_sync),
        .o_fall  (w_m1_fall),
        .o_rise  (w_m1_rise)
    );

    m1_edge_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.irq_sys_n),
        .o_sync  (w_irq_sync),
        .o_fall  (w_unused_irq_fall),
        .o_rise  (w_unused_irq_rise)
    );

`ifdef TRAP_TIMESLICE_EN
    logic [TIMESLICE_W-1:0] r_ts_cnt;

    assign w_ts_hit = (bus.timeslice_limit != '0) && (r_ts_cnt == bus.timeslice_limit);

    // Guest M1 budget counter; parks at the limit so preemption stays requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
        end else if (w_resume) begin
            r_ts_cnt <= '0;
        end else if (w_m1_fall && (r_state == ST_GUEST) && !w_ts_hit) begin
            r_ts_cnt <= r_ts_cnt + TIMESLICE_W'(1);
        end
    end
`else
    logic w_unused_ts;
    assign w_unused_ts = ^bus.timeslice_limit;
    assign w_ts_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HOST;
        else        r_state <= w_state_next;
    end

    // Mode transitions happen only at opcode fetch boundaries; forced entry beats trap entry.
    always_comb begin
        w_state_next   = r_state;
        w_trap_entry   = 1'b0;
        w_forced_entry = 1'b0;
        w_resume       = 1'b0;
        if (w_m1_fall) begin
            case (r_state)
                ST_HOST: begin
                    if (bus.last_isr_jmp && bus.virtual_enabled) begin
                        w_state_next = ST_GUEST;
                        w_resume     = 1'b1;
                    end
                end
                ST_GUEST: begin
                    if (!bus.virtual_enabled) begin
                        w_state_next   = ST_HOST;
                        w_forced_entry = 1'b1;
                    end else if ((|r_pending) && bus.new_isr) begin
                        w_state_next = ST_HOST;
                        w_trap_entry = 1'b1;
                    end
                end
                default: w_state_next = ST_HOST;
            endcase
        end
    end

    // Fixed priority: lowest pending index wins.
    always_comb begin
        w_cause_idx = '0;
        w_clr       = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_cause_idx = CAUSE_W'(i);
                w_clr       = '0;
                w_clr[i]    = 1'b1;
            end
        end
    end

    // New requests are accepted only in guest mode; anything seen in host mode is dropped.
    always_comb begin
        w_set          = bus.trap_req & bus.trap_mask;
        w_set[SRC_IRQ] = !r_irq_n && bus.trap_mask[SRC_IRQ] && !r_suppress;
        w_set[SRC_TS]  = w_set[SRC_TS] | w_ts_hit;
        if (r_state != ST_GUEST) w_set = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_suppress    <= 1'b0;
            r_nmi_n       <= 1'b1;
            r_irq_n       <= 1'b1;
            r_capture     <= 1'b0;
            r_cause       <= '0;
            r_cause_valid <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~(w_trap_entry ? w_clr : '0)) | w_set;
            r_nmi_n   <= !((r_state == ST_GUEST) && (|r_pending));

            if (w_m1_rise) r_irq_n <= w_irq_sync;

            // A held-low IRQ is serviced once; it must go high before it can trap again.
            if (r_irq_n)                r_suppress <= 1'b0;
            else if (w_set[SRC_IRQ])    r_suppress <= 1'b1;

            if (w_m1_fall) r_capture <= w_trap_entry;

            if (w_trap_entry) begin
                r_cause       <= w_cause_idx;
                r_cause_valid <= 1'b1;
            end else if (w_forced_entry) begin
                r_cause_valid <= 1'b0;
            end
        end
    end

    assign bus.trap_state      = r_state;
    assign bus.nmi_n           = r_nmi_n;
    assign bus.irq_n           = r_irq_n;
    assign bus.capture_address = r_capture;
    assign bus.trap_cause      = r_cause;
    assign bus.cause_valid     = r_cause_valid;
    assign bus.pending         = r_pending;
endmodule
